// File: rtl/bch_encoder_param_if.sv
// Handshake bundle for bch_encoder_param: message in, systematic codeword out.
// err_mask exists only when BCH_ENC_ERR_INJ_EN is defined.
interface bch_encoder_param_if #(
   parameter int N = 15,
   parameter int K = 7
);
   logic         in_valid;
   logic         in_ready;
   logic [K-1:0] msg;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] codeword;
`ifdef BCH_ENC_ERR_INJ_EN
   logic [N-1:0] err_mask;
`endif

   modport master (
      output in_valid,
      output msg,
      output out_ready,
`ifdef BCH_ENC_ERR_INJ_EN
      output err_mask,
`endif
      input  in_ready,
      input  out_valid,
      input  codeword
   );

   modport slave (
      input  in_valid,
      input  msg,
      input  out_ready,
`ifdef BCH_ENC_ERR_INJ_EN
      input  err_mask,
`endif
      output in_ready,
      output out_valid,
      output codeword
   );
endinterface

// File: rtl/bch_encoder_param.sv
// Bit-serial systematic BCH encoder: one message bit per cycle, MSB first.
// Optional error injection on the output codeword via macro BCH_ENC_ERR_INJ_EN.
module bch_encoder_param #(
   parameter int           N   = 15,
   parameter int           K   = 7,
   parameter logic [N-K:0] GEN = 9'b111010001
) (
   input  logic                 clk,
   input  logic                 reset,
   bch_encoder_param_if.slave   bus
);

   localparam int PW = N - K;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   if (N <= K) begin : g_bad_nk
      $error("bch_encoder_param: N must exceed K");
   end else if (GEN[N-K] != 1'b1 || GEN[0] != 1'b1) begin : g_bad_gen
      $error("bch_encoder_param: GEN must have x^(N-K) and x^0 terms set");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [K-1:0]  msg_q, msg_d;
   logic [PW-1:0] p_q, p_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fb;
   logic [N-1:0]  err_q, err_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         msg_q   <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fb      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               msg_d   = bus.msg;
               p_d     = '0;
               cnt_d   = CW'(K - 1);
`ifdef BCH_ENC_ERR_INJ_EN
               err_d   = bus.err_mask;
`else
               err_d   = '0;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // LFSR division by GEN; remainder left in p after the last bit
            fb  = msg_q[cnt_q] ^ p_q[PW-1];
            p_d = (p_q << 1) ^ ({PW{fb}} & GEN[PW-1:0]);
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // in_ready also gated by reset so it reads 0 for the whole reset pulse
   assign bus.in_ready  = (state_q == IDLE) && !reset;
   assign bus.out_valid = (state_q == DONE);
   assign bus.codeword  = (state_q == DONE) ? ({msg_q, p_q} ^ err_q) : '0;

endmodule

// File: tb/tb_bch_encoder_param.sv
// Scoreboard bench for bch_encoder_param (defaults N=15, K=7).
module tb_bch_encoder_param;
   localparam int            N   = 15;
   localparam int            K   = 7;
   localparam logic [N-K:0]  GEN = 9'b111010001;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;
   logic [N-1:0] exp_q[$];

   bch_encoder_param_if #(.N(N), .K(K)) bus ();

   bch_encoder_param #(.N(N), .K(K), .GEN(GEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: polynomial long division of msg*x^(N-K) by GEN
   function automatic logic [N-1:0] bch_ref(input logic [K-1:0] m);
      logic [N-1:0] v;
      logic [N-1:0] g;
      v = {m, {(N-K){1'b0}}};
      g = {{(K-1){1'b0}}, GEN};
      for (int i = N-1; i >= N-K; i--)
         if (v[i]) v = v ^ (g << (i - (N-K)));
      return {m, v[N-K-1:0]};
   endfunction

   task automatic drive_mask(input logic [N-1:0] mask);
`ifdef BCH_ENC_ERR_INJ_EN
      bus.err_mask = mask;
`else
      if (mask != '0) $display("note: mask ignored in this build");
`endif
   endtask

   task automatic accept(input logic [K-1:0] m, input logic [N-1:0] mask);
      int n;
      @(negedge clk);
      bus.msg = m;
      bus.in_valid = 1'b1;
      drive_mask(mask);
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", (n < 50), 1);
`ifdef BCH_ENC_ERR_INJ_EN
      exp_q.push_back(bch_ref(m) ^ mask);
`else
      exp_q.push_back(bch_ref(m));
`endif
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.msg = $urandom_range(0, (1 << K) - 1);
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic pop_check(input string tag);
      logic [N-1:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, bus.codeword, e);
      end
   endtask

   task automatic encode(input logic [K-1:0] m, input logic [N-1:0] mask,
                         input string tag, output logic [N-1:0] cw);
      int cyc;
      accept(m, mask);
      wait_out(cyc);
      chk({tag, "_lat"}, cyc, K);
      cw = bus.codeword;
      pop_check(tag);
      @(posedge clk);
      #1;
   endtask

   logic [N-1:0] cw;
   logic [N-1:0] held;
   int           gap;
   int           cyc;
   int           seen;

   initial begin
      n_chk = 0;
      n_fail = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.msg = '0;
      bus.out_ready = 1'b1;
      drive_mask('0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_codeword", bus.codeword, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);

      // Known vectors
      encode(7'h01, '0, "cw_01", cw);
      chk("cw_01_const", cw, 15'h01D1);
      encode(7'h02, '0, "cw_02", cw);
      chk("cw_02_const", cw, 15'h0273);
      encode(7'h03, '0, "cw_03", cw);
      chk("cw_03_const", cw, 15'h03A2);
      encode(7'h7F, '0, "cw_7f", cw);
      chk("cw_7f_const", cw, 15'h7FFF);
      encode(7'h00, '0, "cw_00", cw);
      chk("cw_00_const", cw, 15'h0000);
      for (int i = 0; i < 4; i++) begin
         encode(K'($urandom_range(0, (1 << K) - 1)), '0, "cw_rand", cw);
      end
      chk("idle_after_hs", bus.out_valid, 0);

      // Back-to-back throughput with in_valid held high
      @(negedge clk);
      bus.msg = 7'h03;
      bus.in_valid = 1'b1;
      exp_q.push_back(bch_ref(7'h03));
      exp_q.push_back(bch_ref(7'h03));
      @(posedge clk);
      #1;
      wait_out(cyc);
      chk("thru_lat", cyc, K);
      pop_check("thru_cw0");
      gap = 0;
      do begin
         @(posedge clk);
         #1;
         gap++;
      end while (!bus.out_valid && gap < 50);
      chk("thru_gap", gap, K + 2);
      pop_check("thru_cw1");
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;

      // Backpressure: hold in DONE while in_valid toggles with another msg
      bus.out_ready = 1'b0;
      encode(7'h2A, '0, "bp_cw", cw);
      held = cw;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.in_valid = ~bus.in_valid;
         bus.msg = 7'h55;
         @(posedge clk);
         #1;
         chk("bp_stable", bus.codeword, held);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.msg = 7'h55;
      exp_q.push_back(bch_ref(7'h55));
      @(posedge clk);
      #1;
      chk("hs_no_accept_valid", bus.out_valid, 0);
      chk("hs_no_accept_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("accept_55", bus.in_ready, 0);
      wait_out(cyc);
      chk("cw_55_lat", cyc, K);
      pop_check("cw_55");
      @(posedge clk);
      #1;

      // Reset while a codeword is pending in DONE
      bus.out_ready = 1'b0;
      encode(7'h7F, '0, "pre_rst", cw);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_done_valid", bus.out_valid, 0);
      chk("rst_done_cw", bus.codeword, 0);
      chk("rst_done_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1;

      // Reset three cycles into SHIFT
      accept(7'h01, '0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_shift_valid", bus.out_valid, 0);
      chk("rst_shift_cw", bus.codeword, 0);
      chk("rst_shift_ready", bus.in_ready, 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      chk("rst_no_emit", seen, 0);
      encode(7'h02, '0, "post_rst_cw", cw);
      chk("post_rst_const", cw, 15'h0273);

`ifdef BCH_ENC_ERR_INJ_EN
      encode(7'h01, 15'h0001, "errinj", cw);
      chk("errinj_const", cw, 15'h01D0);
      encode(7'h01, '0, "errinj_clear", cw);
      chk("errinj_clear_const", cw, 15'h01D1);
`endif

      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/bch_encoder_param.md
BCH_ENCODER_PARAM -- requirements
Module: bch_encoder_param

Interface
REQ-001 Parameter N, default 15: codeword length in bits, N > K >= 1.
REQ-002 Parameter K, default 7: message length in bits.
REQ-003 Parameter GEN, default 9'b111010001: generator polynomial, width N-K+1, bit i = coefficient of x^i.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  message present on msg.
REQ-007 in_ready  output  1  block can accept a message.
REQ-008 msg  input  K  message; msg[K-1] is the highest-order coefficient.
REQ-009 out_valid  output  1  codeword is valid and held.
REQ-010 out_ready  input  1  downstream accepts the codeword.
REQ-011 codeword  output  N  systematic codeword {message, parity}.

Function
REQ-012 Message accepted on a rising edge where in_valid and in_ready are both 1; msg is captured into an internal register on that edge.
REQ-013 FSM states: IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE -> SHIFT on accept; parity register cleared to 0 and bit counter loaded to K-1 on the same edge.
REQ-015 SHIFT: one message bit per cycle, MSB first; fb = bit XOR p[N-K-1]; p <= {p[N-K-2:0],0} XOR (fb ? GEN[N-K-1:0] : 0).
REQ-016 SHIFT -> DONE on the edge that processes bit 0, exactly K edges after the accept edge; out_valid rises on that edge.
REQ-017 In DONE: codeword[N-1:N-K] = captured msg; codeword[N-K-1:0] = p = remainder of msg*x^(N-K) mod GEN.
REQ-018 codeword and out_valid stay stable in DONE until out_ready = 1; DONE -> IDLE on the edge where out_valid and out_ready are both 1.
REQ-019 Throughput: one codeword per K+2 cycles minimum with out_ready tied to 1; no accept in the DONE->IDLE handshake cycle.
REQ-020 in_valid and msg changes during SHIFT or DONE are ignored and do not disturb the captured message.
REQ-021 codeword = 0 whenever out_valid = 0.
REQ-022 Elaboration fails if N <= K, GEN[N-K] != 1, or GEN[0] != 1.

Reset
REQ-023 On reset assertion, asynchronously: state = IDLE, parity, counter and message registers = 0, out_valid = 0, codeword = 0, in_ready = 0 while reset is high.
REQ-024 After deassertion, in_ready = 1 from the first clock edge onward.
REQ-025 Reset during SHIFT or DONE discards the partial or pending codeword; no codeword is emitted for that message.

Configuration
REQ-026 Macro BCH_ENC_ERR_INJ_EN defined: adds input err_mask [N-1:0], captured on the accept edge; the output codeword in DONE is the correct codeword XOR the captured mask.
REQ-027 BCH_ENC_ERR_INJ_EN undefined: no err_mask port; codeword is always the error-free codeword.

Verification (defaults N=15, K=7)
REQ-028 msg=7'h01 accepted, out_ready=1 -> out_valid high exactly 7 cycles after accept; codeword=15'h01D1.
REQ-029 msg=7'h02 -> codeword=15'h0273; msg=7'h03 -> codeword=15'h03A2 (XOR of the two, linearity).
REQ-030 msg=7'h7F -> codeword=15'h7FFF; msg=7'h00 -> codeword=15'h0000.
REQ-031 out_ready held 0 for 20 cycles in DONE, in_valid toggled with msg=7'h55 -> codeword stable and in_ready=0 throughout; after out_ready=1, the next accept is msg=7'h55.
REQ-032 Reset pulsed 3 cycles after accept of msg=7'h01 -> out_valid and codeword go to 0 immediately; next msg=7'h02 gives 15'h0273 after 7 cycles.
REQ-033 BCH_ENC_ERR_INJ_EN defined, msg=7'h01, err_mask=15'h0001 -> codeword=15'h01D0.
